// File: rtl/display_interface.sv
// Eight-digit multiplexed seven-segment driver: 8x6 digit RAM, prescaled
// digit scan, and combinational active-low anode/segment/decimal-point outputs.
module display_interface #(
  parameter int unsigned CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       W,
  input  logic [2:0] WADD,
  input  logic [5:0] DIN,
  output logic [7:0] E,
  output logic [7:1] segOut,
  output logic       DP
);

  logic [5:0]       ram_q [8];
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [2:0]       idx_q, idx_d;

  logic [5:0] entry;
  logic       dig_en, dig_dp;
  logic [3:0] dig_hex;
  logic [7:1] pattern;

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == '1) begin
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q   <= '{default: '0};
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      if (W) begin
        ram_q[WADD] <= DIN;
      end
    end
  end

  // RAM read is asynchronous so a write lands on the very next cycle's outputs.
  assign entry   = ram_q[idx_q];
  assign dig_en  = entry[5];
  assign dig_hex = entry[4:1];
  assign dig_dp  = entry[0];

  always_comb begin
    pattern = 7'h7F;
    case (dig_hex)
      4'h0: pattern = 7'h01;
      4'h1: pattern = 7'h4F;
      4'h2: pattern = 7'h12;
      4'h3: pattern = 7'h06;
      4'h4: pattern = 7'h4C;
      4'h5: pattern = 7'h24;
      4'h6: pattern = 7'h20;
      4'h7: pattern = 7'h0F;
      4'h8: pattern = 7'h00;
      4'h9: pattern = 7'h04;
      4'hA: pattern = 7'h08;
      4'hB: pattern = 7'h60;
      4'hC: pattern = 7'h31;
      4'hD: pattern = 7'h42;
      4'hE: pattern = 7'h30;
      4'hF: pattern = 7'h38;
      default: pattern = 7'h7F;
    endcase
  end

  always_comb begin
    E        = '1;
    E[idx_q] = ~dig_en;
    segOut   = dig_en ? pattern : 7'h7F;
    DP       = ~(dig_dp & dig_en);
  end

endmodule

// File: tb/tb_display_interface.sv
// Directed bench for display_interface: table of single-digit writes checked
// at scan index 0, plus scan, same-edge write/advance and reset sequences.
module tb_display_interface;

  localparam int unsigned CW = 3;
  localparam int P = 8;  // cycles per digit = 2**CW

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       W = 1'b0;
  logic [2:0] WADD = '0;
  logic [5:0] DIN = '0;
  logic [7:0] E;
  logic [7:1] segOut;
  logic       DP;

  int checks = 0;
  int errors = 0;
  int t = 0;  // cycles since the last reset edge

  display_interface #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .W(W), .WADD(WADD), .DIN(DIN),
    .E(E), .segOut(segOut), .DP(DP)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] wadd;
    logic [5:0] din;
    logic [7:0] e;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t vecs [18];
  logic [7:0] exp_e   [8];
  logic [6:0] exp_seg [8];

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    t = 0;
  endtask

  task automatic write(input logic [2:0] a, input logic [5:0] d);
    W = 1'b1; WADD = a; DIN = d;
    step();
    W = 1'b0; DIN = 6'h15;
  endtask

  task automatic check(input string name, input logic [7:0] ee,
                       input logic [6:0] es, input logic ed);
    checks++;
    if (E !== ee || segOut !== es || DP !== ed) begin
      errors++;
      $display("FAIL %s t=%0d: got E=%h seg=%h DP=%b, expected E=%h seg=%h DP=%b",
               name, t, E, segOut, DP, ee, es, ed);
    end
  endtask

  initial begin
    int cur, nxt;

    vecs[0]  = '{3'd0, 6'h20, 8'hFE, 7'h01, 1'b1};
    vecs[1]  = '{3'd0, 6'h23, 8'hFE, 7'h4F, 1'b0};
    vecs[2]  = '{3'd0, 6'h24, 8'hFE, 7'h12, 1'b1};
    vecs[3]  = '{3'd0, 6'h27, 8'hFE, 7'h06, 1'b0};
    vecs[4]  = '{3'd0, 6'h28, 8'hFE, 7'h4C, 1'b1};
    vecs[5]  = '{3'd0, 6'h2B, 8'hFE, 7'h24, 1'b0};
    vecs[6]  = '{3'd0, 6'h2C, 8'hFE, 7'h20, 1'b1};
    vecs[7]  = '{3'd0, 6'h2F, 8'hFE, 7'h0F, 1'b0};
    vecs[8]  = '{3'd0, 6'h30, 8'hFE, 7'h00, 1'b1};
    vecs[9]  = '{3'd0, 6'h33, 8'hFE, 7'h04, 1'b0};
    vecs[10] = '{3'd0, 6'h34, 8'hFE, 7'h08, 1'b1};
    vecs[11] = '{3'd0, 6'h37, 8'hFE, 7'h60, 1'b0};
    vecs[12] = '{3'd0, 6'h38, 8'hFE, 7'h31, 1'b1};
    vecs[13] = '{3'd0, 6'h3B, 8'hFE, 7'h42, 1'b0};
    vecs[14] = '{3'd0, 6'h3C, 8'hFE, 7'h30, 1'b1};
    vecs[15] = '{3'd0, 6'h3F, 8'hFE, 7'h38, 1'b0};
    vecs[16] = '{3'd0, 6'h11, 8'hFF, 7'h7F, 1'b1};  // en=0 blanks despite dp
    vecs[17] = '{3'd3, 6'h3F, 8'hFF, 7'h7F, 1'b1};  // other address, digit 0 stays blank

    exp_e   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    exp_seg = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F};

    // Reset only: blank for a full scan
    do_reset();
    check("reset_state", 8'hFF, 7'h7F, 1'b1);
    for (int i = 0; i < 8 * P; i++) begin
      step();
      check("reset_blank_scan", 8'hFF, 7'h7F, 1'b1);
    end

    // Table: write one entry right after reset, read back at scan index 0
    foreach (vecs[k]) begin
      do_reset();
      write(vecs[k].wadd, vecs[k].din);
      check("table_write", vecs[k].e, vecs[k].seg, vecs[k].dp);
      step();
      check("table_hold_w0", vecs[k].e, vecs[k].seg, vecs[k].dp);
    end

    // Digit 7 only, with decimal point
    do_reset();
    write(3'd7, 6'h21);
    for (int i = 0; i < 8 * P; i++) begin
      if ((t / P) % 8 == 7) check("digit7_on", 8'h7F, 7'h01, 1'b0);
      else                  check("digit7_others_blank", 8'hFF, 7'h7F, 1'b1);
      step();
    end

    // All digits hex 0..7, scanned across a wrap
    do_reset();
    for (int a = 0; a < 8; a++) write(3'(a), {1'b1, 4'(a), 1'b0});
    while (t < 2 * P) step();
    for (int i = 0; i < 8 * P + 2 * P; i++) begin
      cur = (t / P) % 8;
      check("scan_order", exp_e[cur], exp_seg[cur], 1'b1);
      step();
    end

    // Blanking write to the scanned digit takes effect next cycle
    while (t % P != 2) step();
    cur = (t / P) % 8;
    check("pre_blank", exp_e[cur], exp_seg[cur], 1'b1);
    write(3'(cur), 6'h11);
    check("blank_next_cycle", 8'hFF, 7'h7F, 1'b1);

    // Write to the next digit on the same edge the scan advances onto it
    while (t % P != P - 1) step();
    nxt = ((t / P) + 1) % 8;
    write(3'(nxt), 6'h3F);
    check("write_with_advance", exp_e[nxt], 7'h38, 1'b0);

    // Reset with a coincident write while digit 3 is displayed
    while (((t / P) % 8) != 3 || (t % P) != 4) step();
    rst = 1'b1; W = 1'b1; WADD = 3'd3; DIN = 6'h3F;
    step();
    rst = 1'b0; W = 1'b0; t = 0;
    for (int i = 0; i < 8 * P; i++) begin
      check("rst_write_discarded", 8'hFF, 7'h7F, 1'b1);
      step();
    end
    write(3'd0, 6'h2A);
    check("scan_restart_phase_d0", 8'hFE, 7'h24, 1'b1);
    while (t % P != 0) step();
    check("scan_restart_phase_d1", 8'hFF, 7'h7F, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
